// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial bit-sequence detector.
//
// Shifts a 1-bit serial stream into a PATTERN_W-bit history and flags when the
// most recent PATTERN_W bits equal a runtime-reloadable pattern (MSB = first
// bit received). Supports overlapping or non-overlapping matches and a
// registered (Moore) or combinational (Mealy) match output.
//
// Optional feature: define SEQDET_MASK_EN to add a per-bit compare mask
// (mask_in port plus mask register, reset to all ones, loaded with the
// pattern). Mask bits at 0 are don't-care positions.
//
// Ports:
//   CLK        in   1          clock, rising edge
//   RESET      in   1          asynchronous active-low reset
//   x          in   1          serial data bit, sampled when en=1
//   en         in   1          bit-valid qualifier; en=0 freezes state
//   load       in   1          load pat_in (priority over en); clears state
//   pat_in     in   PATTERN_W  new pattern, MSB first-received
//   mask_in    in   PATTERN_W  compare mask (SEQDET_MASK_EN only)
//   y          out  1          match indication (Moore pulse or Mealy comb)
//   match_cnt  out  CNT_W      saturating match counter
//   busy_cnt   out  5          bits currently held in history

module seq_detect_param #(
    parameter int unsigned          PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
    parameter bit                   OVERLAP   = 1'b1,
    parameter bit                   MEALY     = 1'b0,
    parameter int unsigned          CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 x,
    input  logic                 en,
    input  logic                 load,
    input  logic [PATTERN_W-1:0] pat_in,
`ifdef SEQDET_MASK_EN
    input  logic [PATTERN_W-1:0] mask_in,
`endif
    output logic                 y,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [4:0]           busy_cnt
);

    localparam int unsigned FILL_W = 5;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PATTERN_W-1:0] pat_q,  pat_d;
    logic [PATTERN_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0]     cnt_q,  cnt_d;
    logic                 y_q,    y_d;

    logic [PATTERN_W-1:0] mask_c;
    logic [PATTERN_W-1:0] hist_next_c;
    logic [FILL_W-1:0]    fill_next_c;
    logic                 match_c;
    logic                 hit_c;

`ifdef SEQDET_MASK_EN
    logic [PATTERN_W-1:0] mask_q, mask_d;

    // Mask register follows the pattern register: reset to all-compare, reload on load.
    always_comb begin
        mask_d = mask_q;
        if (load) begin
            mask_d = mask_in;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_c = mask_q;
`else
    assign mask_c = '1;
`endif

    // Candidate history/fill if the current bit were consumed.
    assign hist_next_c = {hist_q[PATTERN_W-2:0], x};
    assign fill_next_c = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    assign match_c = (((hist_next_c ^ pat_q) & mask_c) == '0) && (fill_next_c == FILL_FULL);

    // A bit presented together with load is discarded, so it can never match.
    assign hit_c = en & ~load & match_c;

    // Next-state logic for pattern, history, fill, counter and Moore output.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        y_d    = 1'b0;
        if (load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            hist_d = hist_next_c;
            fill_d = fill_next_c;
            y_d    = hit_c;
            if (hit_c) begin
                // Non-overlap: next match must be built from PATTERN_W fresh bits.
                if (!OVERLAP) begin
                    fill_d = '0;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
        end
    end

    assign y         = MEALY ? hit_c : y_q;
    assign match_cnt = cnt_q;
    assign busy_cnt  = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four instances (default Moore/overlap,
// non-overlap, Mealy, 2-bit counter) share one input stream.
module tb_seq_detect_param;

    logic       clk;
    logic       RESET;
    logic       x;
    logic       en;
    logic       load;
    logic [3:0] pat_in;

    logic       y_mo, y_no, y_me, y_sa;
    logic [7:0] cnt_mo, cnt_no, cnt_me;
    logic [1:0] cnt_sa;
    logic [4:0] busy_mo, busy_no, busy_me, busy_sa;

    int checks = 0;
    int errors = 0;

    seq_detect_param u_mo (
        .CLK(clk), .RESET(RESET), .x(x), .en(en), .load(load), .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
        .mask_in(4'b1111),
`endif
        .y(y_mo), .match_cnt(cnt_mo), .busy_cnt(busy_mo)
    );

    seq_detect_param #(.OVERLAP(1'b0)) u_no (
        .CLK(clk), .RESET(RESET), .x(x), .en(en), .load(load), .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
        .mask_in(4'b1111),
`endif
        .y(y_no), .match_cnt(cnt_no), .busy_cnt(busy_no)
    );

    seq_detect_param #(.MEALY(1'b1)) u_me (
        .CLK(clk), .RESET(RESET), .x(x), .en(en), .load(load), .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
        .mask_in(4'b1111),
`endif
        .y(y_me), .match_cnt(cnt_me), .busy_cnt(busy_me)
    );

    seq_detect_param #(.CNT_W(2)) u_sa (
        .CLK(clk), .RESET(RESET), .x(x), .en(en), .load(load), .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
        .mask_in(4'b1111),
`endif
        .y(y_sa), .match_cnt(cnt_sa), .busy_cnt(busy_sa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present inputs mid-cycle, then let combinational outputs settle.
    task automatic drive(input logic b, input logic e, input logic l);
        @(negedge clk);
        x    = b;
        en   = e;
        load = l;
        #1;
    endtask

    // Advance past the next rising edge so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        drive(b, 1'b1, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        en    = 1'b0;
        load  = 1'b0;
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
    endtask

    logic [6:0]  a_bits  = 7'b1101101;
    logic [6:0]  a_moore = 7'b0001001;
    logic [6:0]  a_novl  = 7'b0001000;
    logic [3:0]  pat1101 = 4'b1101;
    logic [7:0]  c_bits  = 8'b11010110;
    int          pulses_sa;

    initial begin
        RESET  = 1'b0;
        x      = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        pat_in = 4'b0000;
        #3;
        chk("rst_y", 32'(y_mo), 32'd0);
        chk("rst_cnt", 32'(cnt_mo), 32'd0);
        chk("rst_busy", 32'(busy_mo), 32'd0);
        chk("rst_y_mealy", 32'(y_me), 32'd0);
        #4;
        RESET = 1'b1;

        // Stream 1101101: overlap, non-overlap and Mealy behaviour.
        for (int i = 0; i < 7; i++) begin
            drive(a_bits[6-i], 1'b1, 1'b0);
            chk($sformatf("a_mealy_y%0d", i), 32'(y_me), 32'(a_moore[6-i]));
            tick();
            chk($sformatf("a_moore_y%0d", i), 32'(y_mo), 32'(a_moore[6-i]));
            chk($sformatf("a_novl_y%0d", i), 32'(y_no), 32'(a_novl[6-i]));
        end
        chk("a_cnt_moore", 32'(cnt_mo), 32'd2);
        chk("a_busy_moore", 32'(busy_mo), 32'd4);
        chk("a_cnt_novl", 32'(cnt_no), 32'd1);
        chk("a_busy_novl", 32'(busy_no), 32'd3);
        chk("a_cnt_mealy", 32'(cnt_me), 32'd2);
        chk("a_cnt_sat", 32'(cnt_sa), 32'd2);

        // 1101 x5: 2-bit counter saturates at 3, y keeps pulsing.
        do_reset();
        pulses_sa = 0;
        for (int i = 0; i < 20; i++) begin
            send(pat1101[3 - (i % 4)]);
            chk($sformatf("b_sat_y%0d", i), 32'(y_sa), ((i % 4) == 3) ? 32'd1 : 32'd0);
            if (y_sa) pulses_sa++;
        end
        chk("b_pulses_sat", 32'(pulses_sa), 32'd5);
        chk("b_cnt_sat", 32'(cnt_sa), 32'd3);
        chk("b_cnt_moore", 32'(cnt_mo), 32'd5);

        // Load 0110 after bits 1,1; the bit on x during load is discarded.
        send(1'b1);
        send(1'b1);
        pat_in = 4'b0110;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        chk("c_load_cnt", 32'(cnt_mo), 32'd0);
        chk("c_load_busy", 32'(busy_mo), 32'd0);
        chk("c_load_y", 32'(y_mo), 32'd0);
        chk("c_load_cnt_mealy", 32'(cnt_me), 32'd0);
        // 1101 must not match the new pattern; 0110 completes at bit 8.
        for (int i = 0; i < 8; i++) begin
            drive(c_bits[7-i], 1'b1, 1'b0);
            chk($sformatf("c_mealy_y%0d", i), 32'(y_me), (i == 7) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("c_moore_y%0d", i), 32'(y_mo), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("c_cnt_moore", 32'(cnt_mo), 32'd1);
        chk("c_cnt_mealy", 32'(cnt_me), 32'd1);

        // en=0 freezes state, gates Mealy y, and clears the Moore pulse.
        do_reset();
        send(1'b1);
        send(1'b1);
        send(1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("d_mealy_gated", 32'(y_me), 32'd0);
        tick();
        chk("d_hold_busy", 32'(busy_mo), 32'd3);
        chk("d_hold_y", 32'(y_mo), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        chk("d_mealy_hit", 32'(y_me), 32'd1);
        tick();
        chk("d_moore_hit", 32'(y_mo), 32'd1);
        chk("d_cnt", 32'(cnt_mo), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        chk("d_pulse_clear", 32'(y_mo), 32'd0);
        chk("d_cnt_hold", 32'(cnt_mo), 32'd1);
        chk("d_busy_hold", 32'(busy_mo), 32'd4);

        // Reset mid-stream loses the partial match.
        do_reset();
        send(1'b1);
        send(1'b1);
        send(1'b0);
        @(negedge clk);
        RESET = 1'b0;
        #1;
        chk("e_rst_y", 32'(y_mo), 32'd0);
        chk("e_rst_cnt", 32'(cnt_mo), 32'd0);
        chk("e_rst_busy", 32'(busy_mo), 32'd0);
        RESET = 1'b1;
        send(1'b1);
        chk("e_no_match", 32'(y_mo), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(pat1101[3-i]);
            chk($sformatf("e_y%0d", i), 32'(y_mo), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("e_cnt", 32'(cnt_mo), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
